// File: rtl/sgd_ctrl_pkg.sv
// Shared types and constants for the SGD training sequencer.
package sgd_ctrl_pkg;

  localparam int unsigned LENGTH       = 16;
  localparam int unsigned MAX_FEATURES = 15;
  localparam int unsigned COL_W        = $clog2(MAX_FEATURES + 1);
  localparam int unsigned EPOCH_W      = 8;
  localparam int unsigned LR_W         = 4;

  typedef enum logic [2:0] {
    ST_LOAD    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_RUN     = 3'd3,
    ST_UPDATE  = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // Configuration captured while reset is held.
  typedef struct packed {
    logic [COL_W-1:0]   feat;
    logic [EPOCH_W-1:0] epoch;
    logic [LR_W-1:0]    lr;
  } cfg_t;

endpackage

// File: rtl/sgd_ctrl_deser.sv
// Serial-to-parallel word assembler: LSB-first shift register with a bit counter.
module sgd_ctrl_deser
  import sgd_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = LENGTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  output logic             last_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic [CNT_W-1:0] cnt;

  assign shifted = {bit_in, shreg[WIDTH-1:1]};
  assign last_c  = en && (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg      <= '0;
      cnt        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= last_c;
      if (en) begin
        shreg <= shifted;
        cnt   <= last_c ? '0 : cnt + CNT_W'(1);
      end
      if (last_c) begin
        word <= shifted;
      end
    end
  end

endmodule

// File: rtl/sgd_ctrl.sv
// SGD training sequencer: loads the data memory from the serial stream,
// then walks rows for the configured number of epochs driving the datapath.
module sgd_ctrl
  import sgd_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  S,
  input  logic [COL_W-1:0]      feat,
  input  logic [EPOCH_W-1:0]    epoch,
  input  logic [ADDR_WIDTH-1:0] data_points,
  input  logic [LR_W-1:0]       learn_rate,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_row,
  output logic [COL_W-1:0]      wr_col,
  output logic [LENGTH-1:0]     wr_data,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_row,
  output logic                  dp_start,
  input  logic                  dp_done,
  output logic                  upd_en,
  output logic [LR_W-1:0]       lr_shift,
  output logic [EPOCH_W-1:0]    epoch_cnt,
  output logic                  SGD_DONE
);

  state_e                state, next_state;
  cfg_t                  cfg_q;
  logic [ADDR_WIDTH-1:0] dp_q;
  logic [ADDR_WIDTH-1:0] row_cnt, row_nxt;
  logic [COL_W-1:0]      col_idx, col_nxt;
  logic [EPOCH_W-1:0]    epoch_nxt;
  logic                  load_done_c;
  logic                  deser_en_c;
  logic                  last_bit_c;

  // Config registers track the inputs only while reset is held.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cfg_q.feat  <= feat;
      cfg_q.epoch <= epoch;
      cfg_q.lr    <= learn_rate;
      dp_q        <= data_points;
    end
  end

  assign lr_shift = cfg_q.lr;

  sgd_ctrl_deser #(.WIDTH(LENGTH)) u_deser (
    .clk        (CLK),
    .rst        (RST),
    .en         (deser_en_c),
    .bit_in     (S),
    .word       (wr_data),
    .word_valid (wr_en),
    .last_c     (last_bit_c)
  );

  // Last word of the training set is on the write port this cycle.
  assign load_done_c = wr_en && (wr_row == dp_q) && (wr_col == '0);
  assign deser_en_c  = (state == ST_LOAD) && !load_done_c;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_LOAD;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    row_nxt    = row_cnt;
    col_nxt    = col_idx;
    epoch_nxt  = epoch_cnt;
    case (state)
      ST_LOAD: begin
        if (last_bit_c) begin
          if (col_idx == cfg_q.feat) begin
            col_nxt = '0;
            row_nxt = (row_cnt == dp_q) ? '0 : row_cnt + ADDR_WIDTH'(1);
          end else begin
            col_nxt = col_idx + COL_W'(1);
          end
        end
        if (load_done_c) begin
          next_state = (cfg_q.epoch == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH:   next_state = ST_RD_WAIT;
      ST_RD_WAIT: next_state = ST_RUN;
      ST_RUN: begin
        // The entry cycle (dp_start high) never completes a row.
        if (dp_done && !dp_start) begin
          next_state = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        if (row_cnt == dp_q) begin
          row_nxt = '0;
          if (epoch_cnt == cfg_q.epoch - EPOCH_W'(1)) begin
            next_state = ST_DONE;
          end else begin
            epoch_nxt  = epoch_cnt + EPOCH_W'(1);
            next_state = ST_FETCH;
          end
        end else begin
          row_nxt    = row_cnt + ADDR_WIDTH'(1);
          next_state = ST_FETCH;
        end
      end
      ST_DONE:    next_state = ST_DONE;
      default:    next_state = ST_LOAD;
    endcase
  end

  // Counters and registered strobes derived from the next state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      row_cnt   <= '0;
      col_idx   <= '0;
      epoch_cnt <= '0;
      wr_row    <= '0;
      wr_col    <= '0;
      rd_en     <= 1'b0;
      rd_row    <= '0;
      dp_start  <= 1'b0;
      upd_en    <= 1'b0;
      SGD_DONE  <= 1'b0;
    end else begin
      row_cnt   <= row_nxt;
      col_idx   <= col_nxt;
      epoch_cnt <= epoch_nxt;
      if (last_bit_c) begin
        wr_row <= row_cnt;
        wr_col <= cfg_q.feat - col_idx;
      end
      rd_en    <= (next_state == ST_FETCH);
      if (next_state == ST_FETCH) begin
        rd_row <= row_nxt;
      end
      dp_start <= (next_state == ST_RUN) && (state != ST_RUN);
      upd_en   <= (next_state == ST_UPDATE);
      SGD_DONE <= (next_state == ST_DONE);
    end
  end

endmodule
